bsg_cam_1r1w_alloc_ctrl: RTL and testbench

//  Allocation/replacement controller directly upstream of bsg_cam_1r1w_tag_array.

---
 rtl/bsg_cam_1r1w_alloc_ctrl.sv | 158 +++++++++++++++
 tb/tb_bsg_cam_1r1w_alloc_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_cam_1r1w_alloc_ctrl.sv
// Allocation/replacement controller sitting directly in front of the CAM tag array.
// Latency: 0 cycles. Array writes issue in the same cycle as their ins/clr/yumi handshake.
// Backpressure: a clear stalls an insert; a full array holds the insert until its eviction is yumi'd.
//
// Ports:
//   clk_i, reset_i                  clock, synchronous active-high reset
//   ins_v_i/ins_tag_i/ins_ready_o   insert request (valid/ready); ins_id_o = entry written
//   clr_v_i/clr_id_i/clr_ready_o    clear request (valid/ready)
//   evict_v_o/evict_id_o            pending victim (valid-then-yumi), evict_yumi_i = consumer took it
//   w_v_o/w_set_not_clear_o/w_tag_o one-hot write port toward the tag array
//   w_empty_i                       per-entry empty vector from the tag array (registered there)
//
// Empty entries are filled lowest-index first. Once the array is full, victims are
// chosen round-robin; the pointer moves only on an evict-replace.

module bsg_cam_1r1w_alloc_ctrl #(
  parameter int tag_width_p = 8,
  parameter int els_p       = 4,
  localparam int lg_els_lp  = (els_p == 1) ? 1 : $clog2(els_p)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,

  input  logic                   ins_v_i,
  input  logic [tag_width_p-1:0] ins_tag_i,
  output logic                   ins_ready_o,
  output logic [lg_els_lp-1:0]   ins_id_o,

  input  logic                   clr_v_i,
  input  logic [lg_els_lp-1:0]   clr_id_i,
  output logic                   clr_ready_o,

  output logic                   evict_v_o,
  output logic [lg_els_lp-1:0]   evict_id_o,
  input  logic                   evict_yumi_i,

  output logic [els_p-1:0]       w_v_o,
  output logic                   w_set_not_clear_o,
  output logic [tag_width_p-1:0] w_tag_o,
  input  logic [els_p-1:0]       w_empty_i
);

  typedef enum logic [0:0] {
    eReady = 1'b0,
    eEvict = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [lg_els_lp-1:0] rr_ptr_q, rr_ptr_d;
  logic [lg_els_lp-1:0] victim_q, victim_d;

  logic                 full;
  logic [lg_els_lp-1:0] first_empty;
  logic [lg_els_lp-1:0] rr_ptr_inc;

  function automatic logic [els_p-1:0] onehot(input logic [lg_els_lp-1:0] id);
    onehot = els_p'(1) << id;
  endfunction

  assign full = ~|w_empty_i;

  // Walk from the top down so the lowest set bit is the one left standing.
  always_comb begin
    first_empty = '0;
    for (int i = els_p - 1; i >= 0; i--) begin
      if (w_empty_i[i]) first_empty = lg_els_lp'(i);
    end
  end

  // Explicit wrap so non-power-of-two entry counts never point past the last entry.
  assign rr_ptr_inc = (rr_ptr_q == lg_els_lp'(els_p - 1)) ? '0 : rr_ptr_q + 1'b1;

  // Handshake / write-port decode. Everything is forced low while reset_i is high,
  // which also drops a pending eviction without issuing its write.
  always_comb begin
    ins_ready_o       = 1'b0;
    ins_id_o          = '0;
    clr_ready_o       = 1'b0;
    evict_v_o         = 1'b0;
    evict_id_o        = '0;
    w_v_o             = '0;
    w_set_not_clear_o = 1'b0;
    w_tag_o           = '0;
    if (!reset_i) begin
      w_tag_o = ins_tag_i;
      unique case (state_q)
        eReady: begin
          if (clr_v_i) begin
            // Clear wins over a same-cycle insert; the insert simply retries.
            clr_ready_o = 1'b1;
            w_v_o       = onehot(clr_id_i);
          end else if (ins_v_i && !full) begin
            ins_ready_o       = 1'b1;
            ins_id_o          = first_empty;
            w_v_o             = onehot(first_empty);
            w_set_not_clear_o = 1'b1;
          end
        end
        eEvict: begin
          evict_v_o  = 1'b1;
          evict_id_o = victim_q;
          if (evict_yumi_i) begin
            ins_ready_o       = 1'b1;
            ins_id_o          = victim_q;
            w_v_o             = onehot(victim_q);
            w_set_not_clear_o = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    victim_d = victim_q;
    unique case (state_q)
      eReady: begin
        if (!clr_v_i && ins_v_i && full) begin
          victim_d = rr_ptr_q;
          state_d  = eEvict;
        end
      end
      eEvict: begin
        if (evict_yumi_i) begin
          rr_ptr_d = rr_ptr_inc;
          state_d  = eReady;
        end
      end
      default: state_d = eReady;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= eReady;
      rr_ptr_q <= '0;
      victim_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      victim_q <= victim_d;
    end
  end

`ifndef SYNTHESIS
  a_w_onehot : assert property (@(posedge clk_i) disable iff (reset_i)
    $countones(w_v_o) <= 1);
  a_yumi_v : assert property (@(posedge clk_i) disable iff (reset_i)
    evict_yumi_i |-> evict_v_o);
  a_clr_id : assert property (@(posedge clk_i) disable iff (reset_i)
    clr_v_i |-> ({1'b0, clr_id_i} < (lg_els_lp + 1)'(els_p)));
  a_ins_hold : assert property (@(posedge clk_i) disable iff (reset_i)
    (state_q == eEvict) |-> (ins_v_i && $stable(ins_tag_i)));
`endif

endmodule

// File: tb/tb_bsg_cam_1r1w_alloc_ctrl.sv
// Directed bench for bsg_cam_1r1w_alloc_ctrl with a behavioural 4-entry tag array model.
// Latency: stimulus changes 1 time unit after each rising edge, outputs are checked before the next edge.
// Backpressure: eviction yumi and clears are driven explicitly by each directed step.

module tb_bsg_cam_1r1w_alloc_ctrl;

  localparam int TW = 8;
  localparam int N  = 4;
  localparam int LG = 2;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          ins_v_i;
  logic [TW-1:0] ins_tag_i;
  logic          ins_ready_o;
  logic [LG-1:0] ins_id_o;
  logic          clr_v_i;
  logic [LG-1:0] clr_id_i;
  logic          clr_ready_o;
  logic          evict_v_o;
  logic [LG-1:0] evict_id_o;
  logic          evict_yumi_i;
  logic [N-1:0]  w_v_o;
  logic          w_set_not_clear_o;
  logic [TW-1:0] w_tag_o;
  logic [N-1:0]  w_empty_i;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bsg_cam_1r1w_alloc_ctrl #(.tag_width_p(TW), .els_p(N)) dut (
    .clk_i             (clk),
    .reset_i           (reset_i),
    .ins_v_i           (ins_v_i),
    .ins_tag_i         (ins_tag_i),
    .ins_ready_o       (ins_ready_o),
    .ins_id_o          (ins_id_o),
    .clr_v_i           (clr_v_i),
    .clr_id_i          (clr_id_i),
    .clr_ready_o       (clr_ready_o),
    .evict_v_o         (evict_v_o),
    .evict_id_o        (evict_id_o),
    .evict_yumi_i      (evict_yumi_i),
    .w_v_o             (w_v_o),
    .w_set_not_clear_o (w_set_not_clear_o),
    .w_tag_o           (w_tag_o),
    .w_empty_i         (w_empty_i)
  );

  // Tag array model: valid bits and tags, empty vector registered.
  logic [N-1:0]  valid_q;
  logic [TW-1:0] tag_q [N];

  always_ff @(posedge clk) begin
    if (reset_i) begin
      valid_q <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (w_v_o[i]) begin
          valid_q[i] <= w_set_not_clear_o;
          if (w_set_not_clear_o) tag_q[i] <= w_tag_o;
        end
      end
    end
  end

  assign w_empty_i = ~valid_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs may change 1 unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_i      = 1'b1;
    ins_v_i      = 1'b1;
    ins_tag_i    = 8'hAA;
    clr_v_i      = 1'b1;
    clr_id_i     = 2'd1;
    evict_yumi_i = 1'b0;
    #1;
    // Outputs must be quiet in reset even with requests asserted.
    check("rst_w_v",       32'(w_v_o), 32'h0);
    check("rst_ins_ready", 32'(ins_ready_o), 32'h0);
    check("rst_clr_ready", 32'(clr_ready_o), 32'h0);
    check("rst_evict_v",   32'(evict_v_o), 32'h0);
    check("rst_w_tag",     32'(w_tag_o), 32'h0);
    tick();
    tick();
    reset_i = 1'b0;
    ins_v_i = 1'b0;
    clr_v_i = 1'b0;
    #1;
    check("rst_rr_ptr", 32'(dut.rr_ptr_q), 32'h0);
    check("rst_empty",  32'(w_empty_i), 32'hF);

    // 1) Fill four empty entries back-to-back, lowest first.
    for (int i = 0; i < N; i++) begin
      ins_v_i   = 1'b1;
      ins_tag_i = 8'h10 + 8'(i);
      #1;
      check("fill_ready", 32'(ins_ready_o), 32'h1);
      check("fill_id",    32'(ins_id_o), 32'(i));
      check("fill_w_v",   32'(w_v_o), 32'h1 << i);
      check("fill_set",   32'(w_set_not_clear_o), 32'h1);
      tick();
    end
    ins_v_i = 1'b0;
    #1;
    check("fill_empty", 32'(w_empty_i), 32'h0);
    check("fill_tag3",  32'(tag_q[3]), 32'h13);

    // 2) Full-array insert: eviction of entry 0, yumi on the third eEvict cycle.
    ins_v_i   = 1'b1;
    ins_tag_i = 8'h20;
    #1;
    check("full_ready0", 32'(ins_ready_o), 32'h0);
    check("full_w_v0",   32'(w_v_o), 32'h0);
    tick();
    for (int c = 0; c < 2; c++) begin
      check("ev_v",     32'(evict_v_o), 32'h1);
      check("ev_id",    32'(evict_id_o), 32'h0);
      check("ev_ready", 32'(ins_ready_o), 32'h0);
      check("ev_w_v",   32'(w_v_o), 32'h0);
      tick();
    end
    check("ev_v3", 32'(evict_v_o), 32'h1);
    evict_yumi_i = 1'b1;
    #1;
    check("yumi_ready", 32'(ins_ready_o), 32'h1);
    check("yumi_id",    32'(ins_id_o), 32'h0);
    check("yumi_w_v",   32'(w_v_o), 32'h1);
    check("yumi_set",   32'(w_set_not_clear_o), 32'h1);
    tick();
    evict_yumi_i = 1'b0;
    ins_v_i      = 1'b0;
    #1;
    check("post_ev_v", 32'(evict_v_o), 32'h0);
    check("rr_after1", 32'(dut.rr_ptr_q), 32'h1);
    check("tag0",      32'(tag_q[0]), 32'h20);

    // 3) Four more evictions with immediate yumi: victims 1,2,3,0.
    for (int k = 0; k < 4; k++) begin
      ins_v_i   = 1'b1;
      ins_tag_i = 8'h30 + 8'(k);
      tick();
      check("rr_ev_v",  32'(evict_v_o), 32'h1);
      check("rr_ev_id", 32'(evict_id_o), 32'((k + 1) % 4));
      evict_yumi_i = 1'b1;
      #1;
      check("rr_ins_id", 32'(ins_id_o), 32'((k + 1) % 4));
      tick();
      evict_yumi_i = 1'b0;
      ins_v_i      = 1'b0;
      #1;
      check("rr_drop", 32'(evict_v_o), 32'h0);
    end
    check("rr_wrapped", 32'(dut.rr_ptr_q), 32'h1);
    check("tag_wrap0",  32'(tag_q[0]), 32'h33);

    // 4) Clear and insert together on a full array: clear wins, then insert fills entry 2.
    clr_v_i   = 1'b1;
    clr_id_i  = 2'd2;
    ins_v_i   = 1'b1;
    ins_tag_i = 8'h40;
    #1;
    check("cw_clr_ready", 32'(clr_ready_o), 32'h1);
    check("cw_ins_ready", 32'(ins_ready_o), 32'h0);
    check("cw_w_v",       32'(w_v_o), 32'h4);
    check("cw_set",       32'(w_set_not_clear_o), 32'h0);
    tick();
    clr_v_i = 1'b0;
    #1;
    check("cw_empty",     32'(w_empty_i), 32'h4);
    check("cw_fill_rdy",  32'(ins_ready_o), 32'h1);
    check("cw_fill_id",   32'(ins_id_o), 32'h2);
    check("cw_no_evict",  32'(evict_v_o), 32'h0);
    tick();
    ins_v_i = 1'b0;
    #1;
    check("cw_tag2", 32'(tag_q[2]), 32'h40);

    // 5) Clear held during eEvict stalls until the cycle after returning to eReady.
    ins_v_i   = 1'b1;
    ins_tag_i = 8'h50;
    tick();
    clr_v_i  = 1'b1;
    clr_id_i = 2'd3;
    #1;
    check("st_ev_id",    32'(evict_id_o), 32'h1);
    check("st_clr_rdy0", 32'(clr_ready_o), 32'h0);
    tick();
    check("st_clr_rdy1", 32'(clr_ready_o), 32'h0);
    evict_yumi_i = 1'b1;
    #1;
    check("st_clr_rdy2", 32'(clr_ready_o), 32'h0);
    check("st_ins_id",   32'(ins_id_o), 32'h1);
    tick();
    evict_yumi_i = 1'b0;
    ins_v_i      = 1'b0;
    #1;
    check("st_clr_acc", 32'(clr_ready_o), 32'h1);
    check("st_clr_w_v", 32'(w_v_o), 32'h8);
    tick();
    clr_v_i = 1'b0;
    #1;
    check("st_empty", 32'(w_empty_i), 32'h8);
    check("st_rr",    32'(dut.rr_ptr_q), 32'h2);

    // 6) Reset while an eviction is pending.
    ins_v_i   = 1'b1;
    ins_tag_i = 8'h60;
    #1;
    check("r6_fill_id", 32'(ins_id_o), 32'h3);
    tick();
    ins_tag_i = 8'h61;
    tick();
    check("r6_ev_v",  32'(evict_v_o), 32'h1);
    check("r6_ev_id", 32'(evict_id_o), 32'h2);
    reset_i = 1'b1;
    clr_v_i = 1'b1;
    #1;
    check("r6_in_rst_ev", 32'(evict_v_o), 32'h0);
    check("r6_in_rst_wv", 32'(w_v_o), 32'h0);
    tick();
    reset_i = 1'b0;
    ins_v_i = 1'b0;
    clr_v_i = 1'b0;
    #1;
    check("r6_ev_v_out", 32'(evict_v_o), 32'h0);
    check("r6_w_v",      32'(w_v_o), 32'h0);
    check("r6_state",    32'(dut.state_q), 32'h0);
    check("r6_rr",       32'(dut.rr_ptr_q), 32'h0);
    check("r6_empty",    32'(w_empty_i), 32'hF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
